// File: rtl/spi_reg_bridge_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge_pkg : shared widths, command layout and FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_bridge_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  // Command byte: MSB selects write (1) / read (0), low bits carry start address
  localparam int CMD_WR_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD_RD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_reg_bridge : SPI byte stream to register-bus bridge with burst access
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_spi_data_rx,
  input  logic              i_spi_ready,
  input  logic              i_spi_busy,
  output logic [DATA_W-1:0] o_spi_data_tx,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [DATA_W-1:0] i_reg_rdata
);

  state_t state;
  state_t state_next;

  logic cmd_take;
  logic rd_advance;
  logic wr_take;
  logic re_next;
  logic tx_load;
  logic tx_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping slave select aborts the frame regardless of any byte arriving
  always_comb begin
    state_next = state;
    if (!i_spi_busy) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_spi_ready) begin
            state_next = i_spi_data_rx[CMD_WR_BIT] ? ST_WR_DATA : ST_CMD_RD;
          end
        end
        ST_CMD_RD:  state_next = ST_RD_WAIT;
        ST_RD_WAIT: state_next = ST_RD_DATA;
        ST_RD_DATA: begin
          if (i_spi_ready) begin
            state_next = ST_CMD_RD;
          end
        end
        ST_WR_DATA: state_next = ST_WR_DATA;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_take   = i_spi_busy && i_spi_ready && (state == ST_IDLE);
    rd_advance = i_spi_busy && i_spi_ready && (state == ST_RD_DATA);
    wr_take    = i_spi_busy && i_spi_ready && (state == ST_WR_DATA);
    re_next    = (state_next == ST_CMD_RD);
    tx_load    = (state == ST_RD_WAIT);
    tx_clear   = (state_next == ST_IDLE);
  end

  // Write address advances the cycle after its strobe so the bus sees a stable address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spi_data_tx <= '0;
      o_reg_addr    <= '0;
      o_reg_wdata   <= '0;
      o_reg_we      <= 1'b0;
      o_reg_re      <= 1'b0;
    end else begin
      o_reg_re <= re_next;
      o_reg_we <= wr_take;

      if (cmd_take) begin
        o_reg_addr <= i_spi_data_rx[ADDR_W-1:0];
      end else if (rd_advance || o_reg_we) begin
        o_reg_addr <= o_reg_addr + 1'b1;
      end

      if (wr_take) begin
        o_reg_wdata <= i_spi_data_rx;
      end

      if (tx_clear) begin
        o_spi_data_tx <= '0;
      end else if (tx_load) begin
        o_spi_data_tx <= i_reg_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bridge : directed frames with scoreboard-checked register strobes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_bridge;

  localparam int GAP = 6;

  logic       clk;
  logic       rst;
  logic [7:0] spi_rx;
  logic       spi_ready;
  logic       spi_busy;
  logic [7:0] spi_tx;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  int total = 0;
  int bad   = 0;

  logic [14:0] wq[$];
  logic [6:0]  rq[$];
  logic [7:0]  txq[$];

  int   tx_cd   = 0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;

  spi_reg_bridge #(.ADDR_W(7), .DATA_W(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_spi_data_rx (spi_rx),
    .i_spi_ready   (spi_ready),
    .i_spi_busy    (spi_busy),
    .o_spi_data_tx (spi_tx),
    .o_reg_addr    (reg_addr),
    .o_reg_wdata   (reg_wdata),
    .o_reg_we      (reg_we),
    .o_reg_re      (reg_re),
    .i_reg_rdata   (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data = address + 0x2C, valid the cycle after the read strobe
  always @(posedge clk) begin
    reg_rdata <= reg_re ? ({1'b0, reg_addr} + 8'h2C) : 8'hEE;
  end

  always @(negedge clk) begin
    if (reg_we && reg_re) begin
      total++; bad++;
      $display("FAIL strobe_overlap: we=%0b re=%0b, required not both", reg_we, reg_re);
    end
    if (reg_we) begin
      total++;
      if (prev_we) begin
        bad++;
        $display("FAIL we_back_to_back: we high two cycles, required single pulse");
      end else if (wq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_we: addr=%h data=%h, required no write", reg_addr, reg_wdata);
      end else begin
        logic [14:0] e;
        e = wq.pop_front();
        if ({reg_addr, reg_wdata} !== e) begin
          bad++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   reg_addr, reg_wdata, e[14:8], e[7:0]);
        end
      end
    end
    if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) begin
        total++;
        if (txq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tx: tx=%h, required no pending read", spi_tx);
        end else begin
          logic [7:0] et;
          et = txq.pop_front();
          if (spi_tx !== et) begin
            bad++;
            $display("FAIL tx_data: tx=%h, required %h", spi_tx, et);
          end
        end
      end
    end
    if (reg_re) begin
      total++;
      tx_cd = 2;
      if (prev_re) begin
        bad++;
        $display("FAIL re_back_to_back: re high two cycles, required single pulse");
      end else if (rq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_re: addr=%h, required no read", reg_addr);
      end else begin
        logic [6:0] ea;
        ea = rq.pop_front();
        if (reg_addr !== ea) begin
          bad++;
          $display("FAIL read_addr: addr=%h, required %h", reg_addr, ea);
        end
      end
    end
    prev_we = reg_we;
    prev_re = reg_re;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    spi_rx    = b;
    spi_ready = 1'b1;
    @(negedge clk);
    spi_ready = 1'b0;
    tick(GAP);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"},    spi_tx,             8'h00);
    check({tag, "_addr"},  {1'b0, reg_addr},   8'h00);
    check({tag, "_wdata"}, reg_wdata,          8'h00);
    check({tag, "_we"},    {7'b0, reg_we},     8'h00);
    check({tag, "_re"},    {7'b0, reg_re},     8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    spi_busy  = 1'b0;
    spi_ready = 1'b0;
    spi_rx    = 8'h00;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single write
    spi_busy = 1'b1; tick(1);
    wq.push_back({7'h05, 8'hA5});
    send(8'h85); send(8'hA5);
    spi_busy = 1'b0; tick(3);

    // Single read with latency check
    spi_busy = 1'b1; tick(1);
    rq.push_back(7'h10); txq.push_back(8'h3C);
    spi_rx = 8'h10; spi_ready = 1'b1;
    @(negedge clk); spi_ready = 1'b0;
    check("tx_cycle1", spi_tx, 8'h00);
    @(negedge clk);
    check("tx_cycle2", spi_tx, 8'h00);
    @(negedge clk);
    check("tx_cycle3", spi_tx, 8'h3C);
    tick(GAP);
    check("tx_hold", spi_tx, 8'h3C);
    spi_busy = 1'b0; tick(2);
    check("tx_idle_clear", spi_tx, 8'h00);

    // Burst write across the address wrap
    spi_busy = 1'b1; tick(1);
    wq.push_back({7'h7E, 8'h11});
    wq.push_back({7'h7F, 8'h22});
    wq.push_back({7'h00, 8'h33});
    send(8'hFE); send(8'h11); send(8'h22); send(8'h33);
    spi_busy = 1'b0; tick(3);

    // Burst read: command plus three dummy bytes
    spi_busy = 1'b1; tick(1);
    rq.push_back(7'h20); txq.push_back(8'h4C);
    rq.push_back(7'h21); txq.push_back(8'h4D);
    rq.push_back(7'h22); txq.push_back(8'h4E);
    rq.push_back(7'h23); txq.push_back(8'h4F);
    send(8'h20); send(8'h00); send(8'h00); send(8'h00);
    spi_busy = 1'b0; tick(3);

    // Frame aborted after write command; busy drop beats a simultaneous ready
    spi_busy = 1'b1; tick(1);
    send(8'h83);
    spi_rx = 8'h77; spi_ready = 1'b1; spi_busy = 1'b0;
    @(negedge clk); spi_ready = 1'b0;
    tick(3);
    spi_busy = 1'b1; tick(1);
    rq.push_back(7'h01); txq.push_back(8'h2D);
    send(8'h01);
    spi_busy = 1'b0; tick(3);

    // Reset in the middle of a read burst
    spi_busy = 1'b1; tick(1);
    rq.push_back(7'h40); txq.push_back(8'h6C);
    send(8'h40);
    check("pre_reset_tx", spi_tx, 8'h6C);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midburst_rst");
    rst = 1'b0;
    tick(1);
    wq.push_back({7'h12, 8'h5A});
    send(8'h92); send(8'h5A);
    spi_busy = 1'b0; tick(4);

    total++;
    if (wq.size() != 0 || rq.size() != 0 || txq.size() != 0 || tx_cd != 0) begin
      bad++;
      $display("FAIL leftover: wq=%0d rq=%0d txq=%0d cd=%0d, required all 0",
               wq.size(), rq.size(), txq.size(), tx_cd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
